// File: rtl/sm_input_filter.sv
// Multi-channel input conditioner: synchroniser chain, prescaled stability filter, edge pulses.
// Optional macro SM_INPUT_FILTER_EDGE_EN enables the registered rise/fall outputs.
module sm_input_filter #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               CNT_WIDTH   = 16,
  parameter int               PRESCALE    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] threshold,
  input  logic [WIDTH-1:0]     d,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     rise,
  output logic [WIDTH-1:0]     fall,
  output logic                 tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  q_reg;
  logic [WIDTH-1:0]                  differ;
  logic [WIDTH-1:0]                  change;
  logic                              tick_reg;
  logic [CNT_WIDTH:0]                thr_eff;

  // Stage 0 samples d; the last stage is the synchronised view s.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  generate
    if (PRESCALE == 1) begin : g_ps_bypass
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tick_reg <= 1'b0;
        end else begin
          tick_reg <= enable;
        end
      end
    end else begin : g_ps_count
      localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
      logic [PS_W-1:0] ps_cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ps_cnt_reg <= '0;
          tick_reg   <= 1'b0;
        end else if (enable) begin
          tick_reg   <= (ps_cnt_reg == PS_LAST);
          ps_cnt_reg <= (ps_cnt_reg == PS_LAST) ? '0 : ps_cnt_reg + 1'b1;
        end else begin
          tick_reg   <= 1'b0;
        end
      end
    end
  endgenerate

  // One extra bit so cnt+1 is compared without wrapping; zero threshold acts as one.
  assign thr_eff = (threshold == '0) ? (CNT_WIDTH+1)'(1) : {1'b0, threshold};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [CNT_WIDTH:0]   cnt_inc;

      assign cnt_inc    = {1'b0, cnt_reg} + (CNT_WIDTH+1)'(1);
      assign differ[gi] = s[gi] ^ q_reg[gi];
      assign change[gi] = tick_reg & differ[gi] & (cnt_inc >= thr_eff);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (tick_reg) begin
          if (!differ[gi] || change[gi]) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_inc[CNT_WIDTH-1:0];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= RESET_VAL;
    end else begin
      q_reg <= q_reg ^ change;
    end
  end

  assign q    = q_reg;
  assign tick = tick_reg;

`ifdef SM_INPUT_FILTER_EDGE_EN
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;

  // Pulses share the edge on which q toggles, so they last exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_reg <= '0;
      fall_reg <= '0;
    end else begin
      rise_reg <= change & ~q_reg;
      fall_reg <= change & q_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_sm_input_filter.sv
// Directed bench for sm_input_filter: one unprescaled instance and one with PRESCALE=10.
module tb_sm_input_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic [15:0] thr_a, thr_b;
  logic [7:0]  d_a, d_b;
  logic [7:0]  q_a, rise_a, fall_a, q_b, rise_b, fall_b;
  logic        tick_a, tick_b;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef SM_INPUT_FILTER_EDGE_EN
  localparam logic EDGE_EN = 1'b1;
`else
  localparam logic EDGE_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  sm_input_filter #(
    .WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(16), .PRESCALE(1), .RESET_VAL(8'hA5)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .threshold(thr_a), .d(d_a),
    .q(q_a), .rise(rise_a), .fall(fall_a), .tick(tick_a)
  );

  sm_input_filter #(
    .WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(16), .PRESCALE(10), .RESET_VAL(8'hA7)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .threshold(thr_b), .d(d_b),
    .q(q_b), .rise(rise_b), .fall(fall_b), .tick(tick_b)
  );

  function automatic logic [7:0] edge_exp(input logic [7:0] v);
    return EDGE_EN ? v : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    int per;
    rst = 1'b1; en_a = 1'b1; thr_a = 16'd4; d_a = 8'hA5;
    en_b = 1'b1; thr_b = 16'd3; d_b = 8'hA7;
    #2;
    chk("reset q_a", q_a, 8'hA5);
    chk("reset rise_a", rise_a, 8'h00);
    chk("reset fall_a", fall_a, 8'h00);
    chk("reset tick_a", tick_a, 1'b0);
    chk("reset q_b", q_b, 8'hA7);
    step(2);
    chk("reset held q_a", q_a, 8'hA5);
    chk("reset held tick_a", tick_a, 1'b0);
    rst = 1'b0;
    step(4);
    chk("tick_a running", tick_a, 1'b1);
    chk("idle q_a", q_a, 8'hA5);

    // Latency: channel 1 rises on edge SYNC_STAGES+threshold = 6.
    d_a = 8'hA7;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      chk($sformatf("latency q k=%0d", k), q_a, (k >= 6) ? 8'hA7 : 8'hA5);
      chk($sformatf("latency rise k=%0d", k), rise_a, (k == 6) ? edge_exp(8'h02) : 8'h00);
      chk($sformatf("latency fall k=%0d", k), fall_a, 8'h00);
    end

    // 3-cycle glitch on channel 3 is rejected.
    d_a = 8'hAF;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (k == 3) d_a = 8'hA7;
      chk($sformatf("glitch3 q k=%0d", k), q_a, 8'hA7);
      chk($sformatf("glitch3 rise k=%0d", k), rise_a, 8'h00);
    end

    // 5-cycle pulse passes, then its trailing edge passes 5 edges later.
    d_a = 8'hAF;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 5) d_a = 8'hA7;
      chk($sformatf("pulse5 q k=%0d", k), q_a, (k >= 6 && k < 11) ? 8'hAF : 8'hA7);
      chk($sformatf("pulse5 rise k=%0d", k), rise_a, (k == 6) ? edge_exp(8'h08) : 8'h00);
      chk($sformatf("pulse5 fall k=%0d", k), fall_a, (k == 11) ? edge_exp(8'h08) : 8'h00);
    end

    // All channels toggle together with threshold 1.
    thr_a = 16'd1;
    d_a = 8'h58;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk($sformatf("toggle up q k=%0d", k), q_a, (k >= 3) ? 8'h58 : 8'hA7);
      chk($sformatf("toggle up rise k=%0d", k), rise_a, (k == 3) ? edge_exp(8'h58) : 8'h00);
      chk($sformatf("toggle up fall k=%0d", k), fall_a, (k == 3) ? edge_exp(8'hA7) : 8'h00);
    end
    d_a = 8'hA7;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk($sformatf("toggle dn q k=%0d", k), q_a, (k >= 3) ? 8'hA7 : 8'h58);
      chk($sformatf("toggle dn rise k=%0d", k), rise_a, (k == 3) ? edge_exp(8'hA7) : 8'h00);
      chk($sformatf("toggle dn fall k=%0d", k), fall_a, (k == 3) ? edge_exp(8'h58) : 8'h00);
    end

    // Enable dropped mid-count holds q; threshold 0 then releases it on the next tick.
    thr_a = 16'd5;
    d_a = 8'hE7;
    step(3);
    en_a = 1'b0;
    step(1);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk($sformatf("enable off q k=%0d", k), q_a, 8'hA7);
    end
    chk("enable off tick_a", tick_a, 1'b0);
    en_a = 1'b1;
    thr_a = 16'd0;
    step(1);
    chk("resume q before tick", q_a, 8'hA7);
    chk("resume tick_a", tick_a, 1'b1);
    step(1);
    chk("resume q after tick", q_a, 8'hE7);
    chk("resume rise", rise_a, edge_exp(8'h40));

    // Asynchronous reset mid-run.
    d_a = 8'h00;
    step(2);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst q_a", q_a, 8'hA5);
    chk("midrst rise_a", rise_a, 8'h00);
    chk("midrst fall_a", fall_a, 8'h00);
    chk("midrst tick_a", tick_a, 1'b0);
    chk("midrst q_b", q_b, 8'hA7);
    step(2);
    chk("midrst held q_a", q_a, 8'hA5);
    rst = 1'b0;
    d_a = 8'hA5;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk($sformatf("post rst q k=%0d", k), q_a, 8'hA5);
      chk($sformatf("post rst rise k=%0d", k), rise_a, 8'h00);
      chk($sformatf("post rst fall k=%0d", k), fall_a, 8'h00);
    end

    // Prescaled instance: tick period, then fall on the 3rd tick after s changes.
    waited = 0;
    step(1);
    while (!tick_b && waited < 20) begin
      step(1);
      waited++;
    end
    chk("tick_b found", tick_b, 1'b1);
    per = 0;
    do begin
      step(1);
      per++;
    end while (!tick_b && per < 20);
    chk("tick_b period", per, 10);
    d_b = 8'hA5;
    for (int k = 1; k <= 32; k++) begin
      step(1);
      chk($sformatf("prescale q k=%0d", k), q_b, (k >= 31) ? 8'hA5 : 8'hA7);
      chk($sformatf("prescale fall k=%0d", k), fall_b, (k == 31) ? edge_exp(8'h02) : 8'h00);
      chk($sformatf("prescale rise k=%0d", k), rise_b, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
